delay_line_ctrl: RTL and testbench
==================================

# delay_line_ctrl

Sample-rate delay line controller. It consumes the strobe from `pulse_train_gen` (the `tick` input) and on each strobe does one circular-buffer transaction against external sample memory: read the delayed sample, then write the new one. It returns the delayed sample to the output mixer. It is the stage directly downstream of the pulse train generator in `delay_core`.

## Interface
- `DW`, 16: sample width, signed two's complement.
- `AW`, 12: buffer address width; DEPTH = 2**AW.
- `FBW`, 8: feedback gain width, unsigned Q0.FBW.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `tick`  in  1: one-cycle sample strobe from `pulse_train_gen`.
- `en`  in  1: accept ticks when high.
- `sample_in`  in  DW: new input sample, sampled on the accepted tick.
- `delay_len`  in  AW: delay in samples, sampled on the accepted tick.
- `fb_gain`  in  FBW: feedback gain; ignored unless the feedback feature is compiled in.
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: 1 = write, 0 = read.
- `mem_addr`  out  AW: memory address.
- `mem_wdata`  out  DW: write data.
- `mem_rdata`  in  DW: read data, valid in the `mem_ack` cycle of a read.
- `mem_ack`  in  1: completes the current request.
- `sample_out`  out  DW: delayed sample, registered.
- `out_valid`  out  1: one-cycle pulse when `sample_out` updates.
- `busy`  out  1: high in any state other than IDLE.
- `overrun`  out  1: sticky tick-dropped flag.

## Operation
- FSM states: IDLE, READ, WRITE.
- **IDLE:**
  - On `tick & en`: latch `sample_in` and `delay_len`.
  - If the latched `delay_len` ≠ 0, go to READ.
  - If it is 0, go to WRITE with delayed sample = `sample_in` (bypass; no read is issued).
- **READ:**
  - `mem_req=1`, `mem_we=0`, `mem_addr = (wr_ptr - delay_len) mod DEPTH`.
  - On `mem_ack`, capture `mem_rdata` and go to WRITE.
- **WRITE:**
  - `mem_req=1`, `mem_we=1`, `mem_addr = wr_ptr`, `mem_wdata` = write value.
  - On `mem_ack`: `wr_ptr` increments and wraps DEPTH-1 → 0, `fill` increments, `sample_out` loads the delayed sample, `out_valid` pulses, and the FSM returns to IDLE.
- **Fill guard:**
  - `fill` counts writes since reset and saturates at DEPTH.
  - While `fill < delay_len`, the delayed sample is forced to 0: the read is still performed but its data is discarded.
  - This prevents uninitialised memory from reaching the output.
- **Handshake:** `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered and held stable until `mem_ack`. `mem_ack` is ignored while `mem_req=0`.
- **Tick while busy:** the tick is dropped and `overrun` is set. It stays set until `rst`.
- **`en` low:** new ticks are ignored and do not set `overrun`. An in-flight transaction completes normally.
- **`delay_len` changes:** take effect only at the next accepted tick.

## Timing
- Reset values: `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `sample_out=0`, `out_valid=0`, `busy=0`, `overrun=0`. Internally, `wr_ptr=0`, `fill=0`, state IDLE.
- Assertion of `rst` mid-transaction aborts it and drops `mem_req` asynchronously. No write completes.
- Latency with zero-wait memory (ack in the first `mem_req` cycle):
  - Tick at edge N → READ request during cycle N+1 → WRITE request during cycle N+2.
  - `out_valid` is high in cycle N+3.
  - Each memory wait cycle adds one cycle.
- Bypass (`delay_len=0`): `out_valid` one cycle earlier.
- Minimum accepted tick spacing: 3 cycles plus wait cycles.
- A tick arriving in the same cycle as the final `mem_ack` is dropped and sets `overrun`, because the FSM is not yet IDLE.

## Configuration
- Macro: `DELAY_FEEDBACK_EN`.
- **Defined:** `mem_wdata = sat_DW(sample_in + ((delayed * fb_gain) >>> FBW))`.
  - The product is DW+FBW+1 bits signed.
  - The sum saturates to [-2**(DW-1), 2**(DW-1)-1].
  - During fill, `delayed` = 0.
- **Undefined:** `mem_wdata = sample_in`. `fb_gain` is unused and no multiplier is synthesised.

## Structure
- Package `delay_pkg`: FSM state enum, the saturation function, default DW/AW/FBW constants.
- Sub-module `delay_fb_mix` (combinational multiply–shift–saturate), instantiated only under `DELAY_FEEDBACK_EN`.

## Test plan
All scenarios use AW=3 (DEPTH=8), DW=16, zero-wait memory model unless noted.
- **Reset:** hold `rst` 2 cycles → every output 0, `wr_ptr=0`. Assert `rst` during READ → `mem_req` drops the same cycle and no write is observed.
- **Delay 3:** feed samples 1..12 → `out_valid` outputs are 0,0,0,1,2,3,…,9. Read addresses equal `(wr_ptr-3) mod 8`.
- **Wrap-around:** `delay_len=7`, feed 20 samples → write addresses cycle 0..7,0..; output k equals input k-7 for k≥7, 0 before.
- **Bypass:** `delay_len=0`, input 0x1234 → no read issued, `sample_out=0x1234`, `out_valid` 2 cycles after the tick.
- **Wait states and overrun:**
  - Memory acks after 2 wait cycles; ticks every 3 cycles → second tick dropped, `overrun=1` and sticky, first transaction result correct.
  - `en=0` ticks → no request, `overrun` unchanged.
- **Feedback (with `DELAY_FEEDBACK_EN`):** `delay_len=1`, `fb_gain=0x80`, impulse 0x4000 then zeros → written values 0x4000, 0x2000, 0x1000, …. Input 0x7FFF with delayed 0x7FFF and `fb_gain=0xFF` → write saturates to 0x7FFF.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared types and helpers for the delay line controller.
// Feedback mixing is optional, enabled by DELAY_FEEDBACK_EN.
package delay_pkg;

  localparam int DW_DEF  = 16;
  localparam int AW_DEF  = 12;
  localparam int FBW_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE
  } state_e;

  function automatic logic signed [63:0] sat_dw(
    input logic signed [63:0] v,
    input int unsigned        w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/delay_fb_mix.sv
// Feedback mixer: sample + (delayed * gain) >>> FBW, saturated to DW.
// Only present in builds with DELAY_FEEDBACK_EN defined.
`ifdef DELAY_FEEDBACK_EN
module delay_fb_mix
  import delay_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int FBW = FBW_DEF
) (
  input  logic signed [DW-1:0]  sample_i,
  input  logic signed [DW-1:0]  delayed_i,
  input  logic        [FBW-1:0] gain_i,
  output logic        [DW-1:0]  wdata_o
);

  localparam int PW = DW + FBW + 1;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shr;

  // gain is unsigned Q0.FBW, so zero-extend before the signed multiply
  assign prod = PW'(delayed_i) * PW'($signed({1'b0, gain_i}));
  assign shr  = prod >>> FBW;

  assign wdata_o = DW'(sat_dw(64'(sample_i) + 64'(shr), DW));

endmodule
`endif

// File: rtl/delay_line_ctrl.sv
// Circular-buffer delay line: one read + one write per accepted tick.
// Define DELAY_FEEDBACK_EN to mix the delayed sample back into writes.
module delay_line_ctrl
  import delay_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int FBW = FBW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           en,
  input  logic [DW-1:0]  sample_in,
  input  logic [AW-1:0]  delay_len,
  input  logic [FBW-1:0] fb_gain,
  output logic           mem_req,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           mem_ack,
  output logic [DW-1:0]  sample_out,
  output logic           out_valid,
  output logic           busy,
  output logic           overrun
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] dlen_q;
  logic [AW-1:0] addr_q;
  logic [AW:0]   fill_q;
  logic [DW-1:0] samp_q;
  logic [DW-1:0] dly_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] sout_q;
  logic          req_q;
  logic          we_q;
  logic          vld_q;
  logic          ovr_q;

  logic          idle;
  logic          accept;
  logic          guard;
  logic [DW-1:0] mix_smp;
  logic [DW-1:0] mix_dly;
  logic [DW-1:0] wdata_d;

  assign idle   = (state_q == S_IDLE);
  assign accept = tick & en;
  assign guard  = fill_q < {1'b0, dlen_q};

  // In IDLE the mixer sees the bypass path; in READ it sees the memory.
  assign mix_smp = idle ? sample_in : samp_q;
  assign mix_dly = idle ? sample_in
                 : (guard ? '0 : mem_rdata);

`ifdef DELAY_FEEDBACK_EN
  delay_fb_mix #(
    .DW  (DW),
    .FBW (FBW)
  ) u_mix (
    .sample_i  (mix_smp),
    .delayed_i (mix_dly),
    .gain_i    (fb_gain),
    .wdata_o   (wdata_d)
  );
`else
  logic unused_fb;
  assign unused_fb = ^fb_gain;
  assign wdata_d   = mix_smp;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      dlen_q   <= '0;
      addr_q   <= '0;
      fill_q   <= '0;
      samp_q   <= '0;
      dly_q    <= '0;
      wdata_q  <= '0;
      sout_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      vld_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (accept && !idle) ovr_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            samp_q <= sample_in;
            dlen_q <= delay_len;
            req_q  <= 1'b1;
            if (delay_len != '0) begin
              state_q <= S_READ;
              we_q    <= 1'b0;
              addr_q  <= wr_ptr_q - delay_len;
            end else begin
              state_q <= S_WRITE;
              we_q    <= 1'b1;
              addr_q  <= wr_ptr_q;
              wdata_q <= wdata_d;
              dly_q   <= sample_in;
            end
          end
        end
        S_READ: begin
          if (mem_ack) begin
            state_q <= S_WRITE;
            dly_q   <= mix_dly;
            we_q    <= 1'b1;
            addr_q  <= wr_ptr_q;
            wdata_q <= wdata_d;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (fill_q != DEPTH) fill_q <= fill_q + (AW+1)'(1);
            sout_q   <= dly_q;
            vld_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign sample_out = sout_q;
  assign out_valid  = vld_q;
  assign busy       = !idle;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl (AW=3, DEPTH=8).
// Feedback vectors run only when DELAY_FEEDBACK_EN is defined.
module tb_delay_line_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int FBW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tick = 1'b0;
  logic           en = 1'b1;
  logic [DW-1:0]  sample_in = '0;
  logic [AW-1:0]  delay_len = '0;
  logic [FBW-1:0] fb_gain = '0;
  logic           mem_req;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata = '0;
  logic           mem_ack = 1'b0;
  logic [DW-1:0]  sample_out;
  logic           out_valid;
  logic           busy;
  logic           overrun;

  always #5 clk = ~clk;

  delay_line_ctrl #(.DW(DW), .AW(AW), .FBW(FBW)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .en         (en),
    .sample_in  (sample_in),
    .delay_len  (delay_len),
    .fb_gain    (fb_gain),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  int errors = 0;
  int checks = 0;

  int            waits = 0;
  int            wcnt = 0;
  logic [DW-1:0] mem [8];
  logic          rd_seen = 1'b0;
  logic          wr_seen = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  int            wr_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Memory model: ack after 'waits' stall cycles, driven at negedge
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req && !rst) begin
      if (wcnt >= waits) begin
        mem_ack = 1'b1;
        wcnt = 0;
        if (!mem_we) mem_rdata = mem[mem_addr];
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wr_seen = 1'b1;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
        wr_cnt++;
      end else begin
        rd_seen = 1'b1;
        rd_addr = mem_addr;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick = 1'b0;
    waits = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'hDEAD;
    repeat (2) @(negedge clk);
    chk("reset_outs",
        {mem_req, mem_we, mem_addr, mem_wdata, sample_out,
         out_valid, busy, overrun}, 64'd0);
    rst = 1'b0;
  endtask

  task automatic do_tick(input logic [DW-1:0] din,
                         input logic [AW-1:0] dl, output int lat);
    @(negedge clk);
    rd_seen = 1'b0;
    wr_seen = 1'b0;
    tick = 1'b1;
    sample_in = din;
    delay_len = dl;
    @(negedge clk);
    tick = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [DW-1:0] din;
    logic [AW-1:0] dl;
    logic [DW-1:0] eout;
    logic [AW-1:0] era;
    logic [AW-1:0] ewa;
  } vec_t;

  vec_t          tv [32];
  int            lat;
  int            vc;
  int            base;
  int            reqs;
  logic [DW-1:0] vout;
  logic [DW-1:0] fbx [4];

  initial begin
    for (int k = 0; k < 12; k++) begin
      tv[k].din  = DW'(k + 1);
      tv[k].dl   = 3'd3;
      tv[k].eout = (k >= 3) ? DW'(k - 2) : '0;
      tv[k].era  = AW'(k - 3);
      tv[k].ewa  = AW'(k);
    end
    for (int k = 0; k < 20; k++) begin
      tv[12+k].din  = 16'hA000 + DW'(k);
      tv[12+k].dl   = 3'd7;
      tv[12+k].eout = (k >= 7) ? 16'hA000 + DW'(k - 7) : '0;
      tv[12+k].era  = AW'(k - 7);
      tv[12+k].ewa  = AW'(k);
    end

    for (int i = 0; i < 32; i++) begin
      if (i == 0 || i == 12) do_reset();
      do_tick(tv[i].din, tv[i].dl, lat);
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_lat", i), lat, 3);
      chk($sformatf("v%0d_out", i), sample_out, tv[i].eout);
      chk($sformatf("v%0d_rd", i), {rd_seen, rd_addr},
          {1'b1, tv[i].era});
      chk($sformatf("v%0d_wa", i), {wr_seen, wr_addr},
          {1'b1, tv[i].ewa});
      chk($sformatf("v%0d_wd", i), wr_data, tv[i].din);
    end
    @(negedge clk);
    chk("valid_pulse", out_valid, 0);

    // Bypass: no read, result two cycles after the tick
    do_reset();
    do_tick(16'h1234, 3'd0, lat);
    chk("byp_lat", lat, 2);
    chk("byp_noread", rd_seen, 0);
    chk("byp_out", sample_out, 16'h1234);
    chk("byp_wr", {wr_seen, wr_addr, wr_data}, {1'b1, 3'd0, 16'h1234});

    // Reset while a read is stalled
    do_reset();
    waits = 2;
    base = wr_cnt;
    @(negedge clk);
    tick = 1'b1;
    sample_in = 16'h5555;
    delay_len = 3'd3;
    @(negedge clk);
    tick = 1'b0;
    #1;
    chk("midrd_req", {mem_req, mem_we}, 2'b10);
    rst = 1'b1;
    #1;
    chk("midrd_drop", {mem_req, busy}, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    waits = 0;
    repeat (4) @(negedge clk);
    chk("midrd_nowr", wr_cnt - base, 0);

    // Wait states plus ticks every 3 cycles: later ticks are dropped
    do_reset();
    do_tick(16'h0011, 3'd0, lat);
    waits = 2;
    base = wr_cnt;
    vc = 0;
    vout = '0;
    @(negedge clk);
    tick = 1'b1;
    sample_in = 16'h0022;
    delay_len = 3'd1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (out_valid) begin
        vc = c;
        vout = sample_out;
      end
      tick = (c == 3 || c == 6);
      sample_in = 16'h0099;
    end
    tick = 1'b0;
    chk("ws_vcycle", vc, 7);
    chk("ws_out", vout, 16'h0011);
    chk("ws_onewr", wr_cnt - base, 1);
    chk("ws_ovr", overrun, 1);
    waits = 0;
    do_tick(16'h0033, 3'd0, lat);
    chk("ws_ovr_sticky", overrun, 1);
    chk("ws_next_out", sample_out, 16'h0033);

    // en low: ticks ignored, no overrun
    do_reset();
    en = 1'b0;
    reqs = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_req) reqs++;
      tick = c[0];
    end
    tick = 1'b0;
    @(negedge clk);
    chk("en0_noreq", reqs, 0);
    chk("en0_state", {overrun, busy}, 2'b00);
    en = 1'b1;

`ifdef DELAY_FEEDBACK_EN
    do_reset();
    fb_gain = 8'h80;
    fbx[0] = 16'h4000;
    fbx[1] = 16'h2000;
    fbx[2] = 16'h1000;
    fbx[3] = 16'h0800;
    for (int k = 0; k < 4; k++) begin
      do_tick((k == 0) ? 16'h4000 : 16'h0000, 3'd1, lat);
      chk($sformatf("fb%0d_wd", k), wr_data, fbx[k]);
    end
    do_reset();
    fb_gain = 8'hFF;
    do_tick(16'h7FFF, 3'd0, lat);
    chk("fb_sat", wr_data, 16'h7FFF);
    fb_gain = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
